ps2_rx: RTL

PS2_RX -- requirements
Module: ps2_rx

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_fifo.sv | 51 +++++
 rtl/ps2_rx.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// PS/2 receiver shared definitions.
// FSM encoding, frame constants and default parameter values.
package ps2_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int DEF_FIFO_DEPTH     = 8;
  localparam int DEF_TIMEOUT_CYCLES = 50000;

  // Odd parity: data bits plus parity bit must hold an odd count of ones.
  function automatic logic odd_ok(
    input logic [DATA_BITS-1:0] d,
    input logic                 p
  );
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Received-byte FIFO for the PS/2 receiver.
// Head is zero while empty; a push into a full FIFO is accepted only with a pop.
module ps2_fifo
  import ps2_pkg::*;
#(
  parameter int WIDTH = DATA_BITS,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizers, frame FSM,
// inactivity timeout and a received-byte FIFO.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_ready,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       overflow,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int BW = $clog2(DATA_BITS);

  logic                 clk_s1;
  logic                 clk_s2;
  logic                 clk_hist;
  logic                 dat_s1;
  logic                 dat_s2;
  logic [1:0]           state;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic [TW-1:0]        tcnt;
  logic                 fall;
  logic                 timeout;
  logic                 par_ok;
  logic                 push;
  logic                 full;
  logic                 empty;

  assign fall    = clk_hist & ~clk_s2;
  assign par_ok  = odd_ok(shreg, par_bit);
  assign timeout = (state != S_IDLE) & ~fall
                 & (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign push    = fall & (state == S_STOP)
                 & (dat_s2 == STOP_BIT) & par_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1     <= 1'b1;
      clk_s2     <= 1'b1;
      clk_hist   <= 1'b1;
      dat_s1     <= 1'b1;
      dat_s2     <= 1'b1;
      state      <= S_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tcnt       <= '0;
      overflow   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      clk_s1     <= ps2_clk;
      clk_s2     <= clk_s1;
      clk_hist   <= clk_s2;
      dat_s1     <= ps2_data;
      dat_s2     <= dat_s1;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;

      if (state == S_IDLE || fall) tcnt <= '0;
      else                         tcnt <= tcnt + 1'b1;

      if (push & full & ~rd_ready) overflow <= 1'b1;

      if (timeout) begin
        state     <= S_IDLE;
        frame_err <= 1'b1;
      end else if (fall) begin
        unique case (state)
          S_IDLE: begin
            if (dat_s2 == START_BIT) begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end
          end
          S_DATA: begin
            // LSB arrives first, so shift in from the top.
            shreg   <= {dat_s2, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BW'(DATA_BITS - 1))
              state <= S_PARITY;
          end
          S_PARITY: begin
            par_bit <= dat_s2;
            state   <= S_STOP;
          end
          S_STOP: begin
            parity_err <= ~par_ok;
            frame_err  <= (dat_s2 != STOP_BIT);
            state      <= S_IDLE;
          end
        endcase
      end
    end
  end

  ps2_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shreg),
    .pop       (rd_ready),
    .head      (rd_data),
    .full      (full),
    .empty     (empty)
  );

  assign rd_valid = ~empty;

endmodule
